// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   state_e : multiply-tracking FSM states
//   prio_e  : which hazard case currently owns the hold/flush outputs
//   REG_ZERO: architectural zero register (never a real dependency)
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    EX_BUSY = 2'd1,
    EX_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    PRIO_NONE     = 3'd0,
    PRIO_FREEZE   = 3'd1,
    PRIO_BRANCH   = 3'd2,
    PRIO_EX_STALL = 3'd3,
    PRIO_LOAD_USE = 3'd4
  } prio_e;

  localparam int unsigned REG_ZERO = 0;

endpackage : pipe_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   clr_i        : clear to zero (wins over inc_i)
//   inc_i        : count up by one, sticking at all-ones
//   cnt_o        : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule : sat_counter

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
//   clk_i, rst_i                 : clock, asynchronous active-low reset
//   ifid_rs_i/ifid_rt_i          : sources of the instruction in ID
//   ifid_uses_rt_i               : ID instruction reads rt
//   idex_memread_i, idex_rt_i    : load in EX and its destination
//   mul_start_i, mul_done_i      : multiply start / result valid
//   branch_taken_i               : taken branch resolved in MEM
//   dmem_wait_i                  : data memory not ready (freezes pipe)
//   *_hold_o                     : register keeps its value
//   *_flush_o                    : register loads a NOP
//   mul_abort_o                  : squash in-flight multiply
//   timeout_o                    : sticky memory-timeout flag
//   stall_cnt_o                  : saturating count of pc_hold_o cycles
module pipe_hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic             mul_start_i,
  input  logic             mul_done_i,
  input  logic             branch_taken_i,
  input  logic             dmem_wait_i,
  output logic             pc_hold_o,
  output logic             ifid_hold_o,
  output logic             idex_hold_o,
  output logic             exmem_hold_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             memwb_flush_o,
  output logic             mul_abort_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  import pipe_ctrl_pkg::*;

  // Wide enough to reach TIMEOUT, so saturation never hides the trip point.
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  prio_e             prio;
  logic              ex_stall, load_use;
  logic [WAIT_W-1:0] wait_cnt;

  // Priority decode: freeze beats branch so a branch seen during a freeze
  // is simply serviced in the first unfrozen cycle (MEM keeps presenting it).
  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    ex_stall = ((state_q == RUN) && mul_start_i) ||
               ((state_q == EX_BUSY) && !mul_done_i);
    load_use = idex_memread_i && (idex_rt_i != REG_W'(REG_ZERO)) &&
               ((idex_rt_i == ifid_rs_i) ||
                (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));
    prio = PRIO_NONE;
    if (dmem_wait_i)         prio = PRIO_FREEZE;
    else if (branch_taken_i) prio = PRIO_BRANCH;
    else if (ex_stall)       prio = PRIO_EX_STALL;
    else if (load_use)       prio = PRIO_LOAD_USE;
  end

  always_comb begin
    pc_hold_o     = 1'b0;
    ifid_hold_o   = 1'b0;
    idex_hold_o   = 1'b0;
    exmem_hold_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    memwb_flush_o = 1'b0;
    mul_abort_o   = 1'b0;
    unique case (prio)
      PRIO_FREEZE: begin
        pc_hold_o     = 1'b1;
        ifid_hold_o   = 1'b1;
        idex_hold_o   = 1'b1;
        exmem_hold_o  = 1'b1;
        memwb_flush_o = 1'b1;
      end
      PRIO_BRANCH: begin
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
        exmem_flush_o = 1'b1;
        mul_abort_o   = (state_q != RUN) || mul_start_i;
      end
      PRIO_EX_STALL: begin
        pc_hold_o     = 1'b1;
        ifid_hold_o   = 1'b1;
        idex_hold_o   = 1'b1;
        exmem_flush_o = 1'b1;
      end
      PRIO_LOAD_USE: begin
        pc_hold_o    = 1'b1;
        ifid_hold_o  = 1'b1;
        idex_flush_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Multiply tracker. EX_DONE remembers a result that arrived while frozen,
  // so the thawed cycle does not stall again.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (mul_start_i && !dmem_wait_i && !branch_taken_i) state_d = EX_BUSY;
      EX_BUSY: if (mul_done_i) state_d = dmem_wait_i ? EX_DONE : RUN;
      EX_DONE: if (!dmem_wait_i) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (branch_taken_i && !dmem_wait_i) state_d = RUN;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= RUN;
      timeout_o <= 1'b0;
    end else begin
      state_q <= state_d;
      // Trips on the edge that closes the TIMEOUT-th consecutive wait cycle.
      if (dmem_wait_i && (wait_cnt >= WAIT_LAST)) timeout_o <= 1'b1;
    end
  end

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (!dmem_wait_i),
    .inc_i (dmem_wait_i),
    .cnt_o (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (pc_hold_o),
    .cnt_o (stall_cnt_o)
  );

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=5).
module tb_pipe_hazard_ctrl;

  localparam int REG_W   = 5;
  localparam int CNT_W   = 5;
  localparam int TIMEOUT = 4;

  // {pc_h, ifid_h, idex_h, exmem_h, ifid_f, idex_f, exmem_f, memwb_f, abort}
  typedef logic [8:0] ctrl_t;
  localparam ctrl_t C_NONE     = 9'b0000_0000_0;
  localparam ctrl_t C_FREEZE   = 9'b1111_0001_0;
  localparam ctrl_t C_BRANCH   = 9'b0000_1110_0;
  localparam ctrl_t C_BR_ABORT = 9'b0000_1110_1;
  localparam ctrl_t C_EXST     = 9'b1110_0010_0;
  localparam ctrl_t C_LU       = 9'b1100_0100_0;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [REG_W-1:0] ifid_rs_i, ifid_rt_i, idex_rt_i;
  logic             ifid_uses_rt_i, idex_memread_i;
  logic             mul_start_i, mul_done_i, branch_taken_i, dmem_wait_i;
  logic             pc_hold_o, ifid_hold_o, idex_hold_o, exmem_hold_o;
  logic             ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o;
  logic             mul_abort_o, timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int    checks = 0;
  int    errors = 0;
  ctrl_t sb[$];

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .ifid_uses_rt_i (ifid_uses_rt_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .mul_start_i    (mul_start_i),
    .mul_done_i     (mul_done_i),
    .branch_taken_i (branch_taken_i),
    .dmem_wait_i    (dmem_wait_i),
    .pc_hold_o      (pc_hold_o),
    .ifid_hold_o    (ifid_hold_o),
    .idex_hold_o    (idex_hold_o),
    .exmem_hold_o   (exmem_hold_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_flush_o   (idex_flush_o),
    .exmem_flush_o  (exmem_flush_o),
    .memwb_flush_o  (memwb_flush_o),
    .mul_abort_o    (mul_abort_o),
    .timeout_o      (timeout_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  function automatic ctrl_t observed_ctrl();
    return {pc_hold_o, ifid_hold_o, idex_hold_o, exmem_hold_o,
            ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o, mul_abort_o};
  endfunction

  // Pops the oldest expected control word and compares it with the DUT.
  task automatic check_ctrl(input string tag);
    ctrl_t got, want;
    got  = observed_ctrl();
    want = sb.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive at posedge+1, push expectation, compare at negedge,
  // return aligned at the next posedge+1.
  task automatic step(input logic ms, input logic md, input logic br, input logic dw,
                      input logic mr, input ctrl_t exp, input string tag);
    mul_start_i    = ms;
    mul_done_i     = md;
    branch_taken_i = br;
    dmem_wait_i    = dw;
    idex_memread_i = mr;
    sb.push_back(exp);
    @(negedge clk_i);
    check_ctrl(tag);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    ifid_rs_i = '0; ifid_rt_i = '0; idex_rt_i = '0;
    ifid_uses_rt_i = 1'b0; idex_memread_i = 1'b0;
    mul_start_i = 1'b0; mul_done_i = 1'b0; branch_taken_i = 1'b0; dmem_wait_i = 1'b0;
    #2;
    sb.push_back(C_NONE);
    check_ctrl("reset_ctrl");
    check_val("reset_stall_cnt", 32'(stall_cnt_o), 0);
    check_val("reset_timeout", 32'(timeout_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Load-use on rs: one bubble.
    idex_rt_i = 5'd8; ifid_rs_i = 5'd8;
    step(0, 0, 0, 0, 1, C_LU, "lu_rs");
    check_val("lu_rs_cnt", 32'(stall_cnt_o), 1);
    step(0, 0, 0, 0, 0, C_NONE, "lu_rs_after");
    // Load-use on rt only when the ID instruction reads rt.
    idex_rt_i = 5'd9; ifid_rs_i = 5'd3; ifid_rt_i = 5'd9; ifid_uses_rt_i = 1'b1;
    step(0, 0, 0, 0, 1, C_LU, "lu_rt");
    ifid_uses_rt_i = 1'b0;
    step(0, 0, 0, 0, 1, C_NONE, "lu_rt_unused");
    // Zero register never creates a dependency.
    idex_rt_i = 5'd0; ifid_rs_i = 5'd0; ifid_rt_i = 5'd0;
    step(0, 0, 0, 0, 1, C_NONE, "lu_r0");
    check_val("lu_cnt", 32'(stall_cnt_o), 2);

    // Multiply: done 3 cycles after start, 3 stall cycles.
    step(1, 0, 0, 0, 0, C_EXST, "mul_c0");
    step(0, 0, 0, 0, 0, C_EXST, "mul_c1");
    step(0, 0, 0, 0, 0, C_EXST, "mul_c2");
    step(0, 1, 0, 0, 0, C_NONE, "mul_done");
    step(0, 0, 0, 0, 0, C_NONE, "mul_run");
    check_val("mul_cnt", 32'(stall_cnt_o), 5);

    // Branch while multiplying aborts it; branch in RUN alone does not.
    step(1, 0, 0, 0, 0, C_EXST, "brmul_start");
    step(0, 0, 0, 0, 0, C_EXST, "brmul_busy");
    step(0, 0, 1, 0, 0, C_BR_ABORT, "brmul_branch");
    step(0, 0, 0, 0, 0, C_NONE, "brmul_run");
    step(0, 0, 1, 0, 0, C_BRANCH, "br_run");
    step(1, 0, 1, 0, 0, C_BR_ABORT, "br_with_start");
    step(0, 0, 0, 0, 0, C_NONE, "br_start_run");
    check_val("br_cnt", 32'(stall_cnt_o), 7);

    // Multiply result lands during a 2-cycle freeze.
    step(1, 0, 0, 0, 0, C_EXST, "frz_start");
    step(0, 1, 0, 1, 0, C_FREEZE, "frz_done0");
    step(0, 1, 0, 1, 0, C_FREEZE, "frz_done1");
    step(0, 0, 0, 0, 0, C_NONE, "frz_thaw");
    check_val("frz_cnt", 32'(stall_cnt_o), 10);

    // Branch held across a 3-cycle freeze, serviced in cycle 4.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, C_FREEZE, "brfrz_hold");
    step(0, 0, 1, 0, 0, C_BRANCH, "brfrz_service");
    step(0, 0, 0, 0, 0, C_NONE, "brfrz_after");
    check_val("brfrz_timeout", 32'(timeout_o), 0);

    // Timeout: 3 waits, a gap, then 4 consecutive waits.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, C_FREEZE, "to_run3");
    check_val("to_after3", 32'(timeout_o), 0);
    step(0, 0, 0, 0, 0, C_NONE, "to_gap");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, C_FREEZE, "to_run4");
    check_val("to_before4th", 32'(timeout_o), 0);
    step(0, 0, 0, 1, 0, C_FREEZE, "to_4th");
    check_val("to_after4th", 32'(timeout_o), 1);
    step(0, 0, 0, 0, 0, C_NONE, "to_idle");
    check_val("to_sticky", 32'(timeout_o), 1);
    check_val("to_cnt", 32'(stall_cnt_o), 20);

    // Stall counter saturates at all-ones (31 for 5 bits).
    for (int i = 0; i < 13; i++) step(0, 0, 0, 1, 0, C_FREEZE, "sat_fill");
    check_val("sat_cnt", 32'(stall_cnt_o), 31);
    step(0, 0, 0, 0, 0, C_NONE, "sat_idle");

    // Reset in the middle of a multiply returns straight to RUN.
    step(1, 0, 0, 0, 0, C_EXST, "rst_mul_start");
    step(0, 0, 0, 0, 0, C_EXST, "rst_mul_busy");
    mul_start_i = 1'b0;
    rst_i = 1'b0;
    #1;
    check_val("rst_mid_cnt", 32'(stall_cnt_o), 0);
    check_val("rst_mid_timeout", 32'(timeout_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    step(0, 0, 0, 0, 0, C_NONE, "rst_mid_run");
    check_val("rst_mid_cnt_after", 32'(stall_cnt_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
